// File: rtl/bullet_pkg.sv
// Shared constants and types for the bullet pool.
//   - DEF_* : default parameter values used by bullet_pool and its encoder
//   - SHOTS_W : width of the accepted-shot counter
//   - slot_op_e : what a single slot does on a given edge
//   - idx_width() : index width for a pool of n slots (at least 1 bit)
package bullet_pkg;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_X_W       = 8;
  localparam int DEF_Y_W       = 8;
  localparam int DEF_Y_MAX     = 119;
  localparam int DEF_STEP      = 1;
  localparam int DEF_COOLDOWN  = 3;
  localparam int SHOTS_W       = 16;

  // Per-slot action on one edge. A freshly loaded slot is handled apart
  // from this, because loading only ever targets a slot that is HOLD.
  typedef enum logic [1:0] {
    SLOT_HOLD    = 2'd0,  // inactive: x/y frozen
    SLOT_ADVANCE = 2'd1,  // active and still on screen: y += STEP
    SLOT_RETIRE  = 2'd2,  // active but would leave the screen: clear
    SLOT_KILL    = 2'd3   // active and hit: clear
  } slot_op_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lowest_free_enc.sv
// Combinational lowest-index free slot finder.
//   active   : slot occupied flags
//   index    : lowest index whose active bit is 0 (0 when none free)
//   any_free : at least one slot is free
module lowest_free_enc
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  localparam int IDX_W    = idx_width(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] active,
  output logic [IDX_W-1:0]     index,
  output logic                 any_free
);

  // Scan from the top down so the last hit (the lowest free slot) wins.
  always_comb begin
    index    = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        index    = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Fixed pool of projectile slots advanced once per movement tick.
//   movement_handler_clock : tick clock, all state updates on rising edge
//   reset       : synchronous active-high clear of every output and state
//   fire        : shot request, sampled each edge
//   ship_x      : x loaded into the slot of an accepted shot
//   kill_mask   : per-slot clear of active bullets (collision)
//   bullet_x/y  : flattened per-slot coordinates, slot i at [i*W +: W]
//   active      : per-slot occupied flags
//   fire_ack    : one-edge pulse when a shot was accepted
//   pool_full   : every slot active after this edge
//   shots_fired : accepted-shot counter, wraps modulo 2^16
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int STEP      = DEF_STEP,
  parameter int COOLDOWN  = DEF_COOLDOWN
) (
  input  logic                     movement_handler_clock,
  input  logic                     reset,
  input  logic                     fire,
  input  logic [X_W-1:0]           ship_x,
  input  logic [NUM_SLOTS-1:0]     kill_mask,
  output logic [NUM_SLOTS*X_W-1:0] bullet_x,
  output logic [NUM_SLOTS*Y_W-1:0] bullet_y,
  output logic [NUM_SLOTS-1:0]     active,
  output logic                     fire_ack,
  output logic                     pool_full,
  output logic [SHOTS_W-1:0]       shots_fired
);

  localparam int IDX_W = idx_width(NUM_SLOTS);
  // Cooldown counter must hold COOLDOWN itself; keep one bit when it is 0.
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [NUM_SLOTS-1:0] active_reg;
  logic [NUM_SLOTS-1:0] active_next;
  logic [X_W-1:0]       x_reg  [NUM_SLOTS];
  logic [X_W-1:0]       x_next [NUM_SLOTS];
  logic [Y_W-1:0]       y_reg  [NUM_SLOTS];
  logic [Y_W-1:0]       y_next [NUM_SLOTS];
  logic                 fire_ack_reg;
  logic                 pool_full_reg;
  logic [SHOTS_W-1:0]   shots_reg;
  logic [CD_W-1:0]      cooldown_reg;
  logic [CD_W-1:0]      cooldown_next;

  logic [IDX_W-1:0]     free_idx;
  logic                 free_any;
  logic                 accept;

  // Free-slot search looks at the pre-edge active vector, so a slot freed
  // by kill or retire on this edge is only reusable from the next edge on.
  lowest_free_enc #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_free_enc (
    .active   (active_reg),
    .index    (free_idx),
    .any_free (free_any)
  );

  assign accept = fire && (cooldown_reg == '0) && free_any;

  always_comb begin
    cooldown_next = cooldown_reg;
    if (accept) begin
      cooldown_next = CD_W'(COOLDOWN);
    end else if (cooldown_reg != '0) begin
      cooldown_next = cooldown_reg - CD_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [Y_W:0] y_sum;
      slot_op_e     op;
      logic         load;

      // One extra bit so y + STEP cannot wrap before the off-screen test.
      assign y_sum = {1'b0, y_reg[gi]} + (Y_W + 1)'(STEP);

      assign op = !active_reg[gi]                 ? SLOT_HOLD   :
                  kill_mask[gi]                   ? SLOT_KILL   :
                  (y_sum > (Y_W + 1)'(Y_MAX))     ? SLOT_RETIRE :
                                                    SLOT_ADVANCE;

      // Only a slot that was free before the edge can be loaded, so a load
      // never collides with an advance of the same slot.
      assign load = accept && (free_idx == IDX_W'(gi));

      assign active_next[gi] = load || (op == SLOT_ADVANCE);
      assign x_next[gi]      = load ? ship_x : x_reg[gi];
      assign y_next[gi]      = load                 ? '0              :
                               (op == SLOT_ADVANCE) ? y_sum[Y_W-1:0] :
                                                      y_reg[gi];

      assign bullet_x[gi*X_W +: X_W] = x_reg[gi];
      assign bullet_y[gi*Y_W +: Y_W] = y_reg[gi];
    end
  endgenerate

  always_ff @(posedge movement_handler_clock) begin
    if (reset) begin
      active_reg    <= '0;
      fire_ack_reg  <= 1'b0;
      pool_full_reg <= 1'b0;
      shots_reg     <= '0;
      cooldown_reg  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_reg[i] <= '0;
        y_reg[i] <= '0;
      end
    end else begin
      active_reg    <= active_next;
      fire_ack_reg  <= accept;
      pool_full_reg <= &active_next;
      cooldown_reg  <= cooldown_next;
      if (accept) begin
        shots_reg <= shots_reg + SHOTS_W'(1);
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_reg[i] <= x_next[i];
        y_reg[i] <= y_next[i];
      end
    end
  end

  assign active      = active_reg;
  assign fire_ack    = fire_ack_reg;
  assign pool_full   = pool_full_reg;
  assign shots_fired = shots_reg;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: a stimulus process drives random and
// directed sequences and pushes the reference model's expected outputs; a
// monitor pops and compares after every edge. A second small instance
// (two slots, no cooldown, everything killed) runs the counter to wrap.
module tb_bullet_pool;

  localparam int NS   = 4;
  localparam int XW   = 8;
  localparam int YW   = 8;
  localparam int YMAX = 119;
  localparam int STP  = 1;
  localparam int CD   = 3;

  typedef struct {
    logic [NS-1:0]    act;
    logic [NS*XW-1:0] bx;
    logic [NS*YW-1:0] by;
    logic             ack;
    logic             full;
    logic [15:0]      shots;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             fire;
  logic [XW-1:0]    ship_x;
  logic [NS-1:0]    kill_mask;
  logic [NS*XW-1:0] bullet_x;
  logic [NS*YW-1:0] bullet_y;
  logic [NS-1:0]    active;
  logic             fire_ack;
  logic             pool_full;
  logic [15:0]      shots_fired;

  logic             wreset;
  logic             wfire;
  logic [XW-1:0]    wship_x;
  logic [1:0]       wkill;
  logic [2*XW-1:0]  wbx;
  logic [2*YW-1:0]  wby;
  logic [1:0]       wact;
  logic             wack;
  logic             wfull;
  logic [15:0]      wshots;

  int checks   = 0;
  int failures = 0;
  bit stim_done = 0;
  bit wrap_done = 0;
  exp_t q[$];

  // Reference model state (plain integers, whole-slot view)
  int m_x[NS];
  int m_y[NS];
  bit m_act[NS];
  int m_cd;
  int m_shots;

  bullet_pool #(
    .NUM_SLOTS(NS), .X_W(XW), .Y_W(YW), .Y_MAX(YMAX), .STEP(STP), .COOLDOWN(CD)
  ) dut (
    .movement_handler_clock(clk),
    .reset       (reset),
    .fire        (fire),
    .ship_x      (ship_x),
    .kill_mask   (kill_mask),
    .bullet_x    (bullet_x),
    .bullet_y    (bullet_y),
    .active      (active),
    .fire_ack    (fire_ack),
    .pool_full   (pool_full),
    .shots_fired (shots_fired)
  );

  bullet_pool #(
    .NUM_SLOTS(2), .X_W(XW), .Y_W(YW), .Y_MAX(YMAX), .STEP(STP), .COOLDOWN(0)
  ) dut_wrap (
    .movement_handler_clock(clk),
    .reset       (wreset),
    .fire        (wfire),
    .ship_x      (wship_x),
    .kill_mask   (wkill),
    .bullet_x    (wbx),
    .bullet_y    (wby),
    .active      (wact),
    .fire_ack    (wack),
    .pool_full   (wfull),
    .shots_fired (wshots)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Apply one edge's inputs and push what the outputs must be after it.
  task automatic step(input logic f, input logic [NS-1:0] k, input logic [XW-1:0] sx,
                      input logic r);
    exp_t e;
    int   idx;
    bit   ack;
    @(negedge clk);
    fire = f; kill_mask = k; ship_x = sx; reset = r;
    ack = 0;
    if (r) begin
      for (int i = 0; i < NS; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_act[i] = 0;
      end
      m_cd = 0;
      m_shots = 0;
    end else begin
      idx = -1;
      for (int i = 0; i < NS; i++) if (!m_act[i] && idx < 0) idx = i;
      for (int i = 0; i < NS; i++) begin
        if (m_act[i]) begin
          if (k[i]) m_act[i] = 0;
          else if (m_y[i] + STP > YMAX) m_act[i] = 0;
          else m_y[i] = m_y[i] + STP;
        end
      end
      if (f && m_cd == 0 && idx >= 0) begin
        m_x[idx] = int'(sx); m_y[idx] = 0; m_act[idx] = 1;
        m_shots = (m_shots + 1) % 65536;
        m_cd = CD;
        ack = 1;
      end else if (m_cd > 0) begin
        m_cd = m_cd - 1;
      end
    end
    e.full = 1;
    for (int i = 0; i < NS; i++) begin
      e.act[i]          = m_act[i];
      e.bx[i*XW +: XW]  = XW'(m_x[i]);
      e.by[i*YW +: YW]  = YW'(m_y[i]);
      e.full            = e.full & m_act[i];
    end
    e.ack   = ack;
    e.shots = 16'(m_shots);
    q.push_back(e);
  endtask

  // Monitor: every edge the DUT presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("active",      64'(active),      64'(e.act));
        chk("bullet_x",    64'(bullet_x),    64'(e.bx));
        chk("bullet_y",    64'(bullet_y),    64'(e.by));
        chk("fire_ack",    64'(fire_ack),    64'(e.ack));
        chk("pool_full",   64'(pool_full),   64'(e.full));
        chk("shots_fired", 64'(shots_fired), 64'(e.shots));
      end
    end
  end

  // Main stimulus
  initial begin
    reset = 1'b1; fire = 1'b0; ship_x = '0; kill_mask = '0;
    step(0, '0, 8'd0, 1);
    step(0, '0, 8'd0, 1);
    // single shot at x=42, then let it fly off the top and retire
    step(1, '0, 8'd42, 0);
    repeat (125) step(0, '0, 8'd0, 0);
    // fire held high: fills the pool, then requests are refused while full
    for (int i = 0; i < 20; i++) step(1, '0, XW'($urandom_range(0, 255)), 0);
    // kill slot 2 while still firing: reloaded one edge later
    step(1, 4'b0100, 8'd99, 0);
    step(1, '0, 8'd100, 0);
    repeat (3) step(0, '0, 8'd0, 0);
    // reset pulse mid-flight, then an immediate shot
    step(1, 4'b0011, 8'd5, 1);
    step(1, '0, 8'd77, 0);
    repeat (4) step(0, '0, 8'd0, 0);
    // random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [NS-1:0] k;
      for (int b = 0; b < NS; b++) k[b] = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 9) < 6, k, XW'($urandom_range(0, 255)),
           $urandom_range(0, 199) == 0);
    end
    step(0, '0, 8'd0, 0);
    stim_done = 1;
  end

  // Counter wrap: one accept per edge with every slot killed each edge.
  initial begin
    wreset = 1'b1; wfire = 1'b0; wkill = 2'b00; wship_x = 8'd7;
    repeat (3) @(negedge clk);
    wreset = 1'b0; wfire = 1'b1; wkill = 2'b11;
    @(posedge clk); #1;
    chk("wrap_first_ack",   64'(wack),   64'd1);
    chk("wrap_first_count", 64'(wshots), 64'd1);
    repeat (65534) @(posedge clk);
    #1;
    chk("wrap_ffff_count", 64'(wshots), 64'hFFFF);
    chk("wrap_ffff_ack",   64'(wack),   64'd1);
    @(posedge clk); #1;
    chk("wrap_zero_count", 64'(wshots), 64'd0);
    chk("wrap_zero_ack",   64'(wack),   64'd1);
    wfire = 1'b0;
    wrap_done = 1;
  end

  // Bounded end-of-run
  initial begin
    int c;
    c = 0;
    while (!(stim_done && wrap_done && q.size() == 0) && c < 90000) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (!(stim_done && wrap_done && q.size() == 0)) begin
      failures++;
      $display("FAIL timeout pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
